// File: rtl/shift_load_ctrl.sv
// shift_load_ctrl: serialises a requested word MSB-first into an attached
// shift register, then reads it back and reports whether it arrived intact.
module shift_load_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             pause,
  output logic             sr_we,
  output logic             sr_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_match,
  output logic             busy,
  output logic [7:0]       err_cnt
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, RESP} state_t;
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic           w_shift;
  logic [CW-1:0]  w_idx;
  // Status outputs are masked by rst so nothing is visible during a sync reset.
  assign w_shift   = ~rst & (r_state == SHIFT);
  assign w_idx     = CW'(WIDTH - 1) - r_cnt;
  assign sr_we     = w_shift & ~pause;
  assign sr_in     = w_shift & r_hold[w_idx];
  assign req_ready = ~rst & (r_state == IDLE);
  assign rsp_valid = ~rst & (r_state == RESP);
  assign busy      = ~rst & (r_state != IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hold    <= '0;
      rsp_data  <= '0;
      rsp_match <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_hold  <= req_data;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: if (!pause) begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= SETTLE;
        end
        SETTLE: begin
          rsp_data  <= sr_out;
          rsp_match <= sr_out == r_hold;
          if (sr_out != r_hold && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          r_state   <= RESP;
        end
        RESP: if (rsp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_load_ctrl.sv
// tb_shift_load_ctrl: directed vectors plus hand sequences for stall,
// saturation and mid-transfer reset, against a behavioural shift register.
module tb_shift_load_ctrl;
  logic       clk = 1'b0;
  logic       rst, req_valid, pause, rsp_ready, stuck;
  logic [7:0] req_data;
  logic       req_ready, sr_we, sr_in, rsp_valid, rsp_match, busy;
  logic [7:0] sr_out, rsp_data, err_cnt;
  logic [7:0] sr_model = 8'h00;
  int n_chk = 0;
  int n_fail = 0;

  shift_load_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .pause(pause), .sr_we(sr_we), .sr_in(sr_in),
    .sr_out(sr_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_match(rsp_match), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (sr_we) sr_model <= {sr_model[6:0], sr_in};
  assign sr_out = stuck ? 8'h00 : sr_model;

  typedef struct {
    logic [7:0] data;
    int         pause_at;
    int         pause_len;
    bit         stuck;
    int         lat;
    logic [7:0] rsp;
    bit         match;
    int         err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t t);
    int bits, pz, pz_we, lat;
    logic [7:0] got;
    stuck = t.stuck;
    @(negedge clk);
    chk("vec ready", req_ready, 1);
    req_valid = 1'b1;
    req_data  = t.data;
    @(posedge clk);
    #1 req_valid = 1'b0;
    bits = 0; pz = 0; pz_we = 0; lat = -1; got = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      pause = (bits == t.pause_at) && (pz < t.pause_len);
      @(negedge clk);
      if (pause) begin
        pz++;
        if (sr_we) pz_we++;
      end
      if (sr_we) begin
        got = {got[6:0], sr_in};
        bits++;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
    chk("latency", lat, t.lat);
    chk("enabled cycles", bits, 8);
    chk("bit sequence", got, t.data);
    chk("we during pause", pz_we, 0);
    chk("rsp_data", rsp_data, t.rsp);
    chk("rsp_match", rsp_match, t.match);
    chk("err_cnt", err_cnt, t.err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v[7];
    int lat, seen, tmo;
    v[0] = '{8'hB3, 0, 0, 1'b0, 10, 8'hB3, 1'b1, 0};
    v[1] = '{8'h5A, 4, 3, 1'b0, 13, 8'h5A, 1'b1, 0};
    v[2] = '{8'hFF, 0, 2, 1'b0, 12, 8'hFF, 1'b1, 0};
    v[3] = '{8'h01, 7, 1, 1'b0, 11, 8'h01, 1'b1, 0};
    v[4] = '{8'h5A, 0, 0, 1'b1, 10, 8'h00, 1'b0, 1};
    v[5] = '{8'h00, 0, 0, 1'b1, 10, 8'h00, 1'b1, 1};
    v[6] = '{8'hA5, 2, 4, 1'b0, 14, 8'hA5, 1'b1, 1};
    rst = 1'b1; req_valid = 1'b0; req_data = 8'h00; pause = 1'b1;
    rsp_ready = 1'b1; stuck = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst sr_we", sr_we, 0);
    chk("rst sr_in", sr_in, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0; pause = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", req_ready, 1);
    chk("post-rst busy", busy, 0);
    chk("post-rst rsp_valid", rsp_valid, 0);
    chk("post-rst err_cnt", err_cnt, 0);
    chk("post-rst rsp_data", rsp_data, 0);
    chk("post-rst rsp_match", rsp_match, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) run_vec(v[i]);

    // Response held under backpressure while a new request waits.
    stuck = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'h3C;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp latency", lat, 10);
    req_valid = 1'b1; req_data = 8'h11;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp rsp_valid", rsp_valid, 1);
      chk("bp rsp_data", rsp_data, 8'h3C);
      chk("bp req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("gap rsp_valid", rsp_valid, 0);
    chk("gap req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    chk("queued latency", lat, 10);
    chk("queued rsp_data", rsp_data, 8'h11);
    @(posedge clk);
    #1;

    // Error counter saturation.
    stuck = 1'b1; tmo = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_data = 8'h5A;
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(lat);
      if (lat < 0) tmo++;
      if (i == 252) chk("err before sat", err_cnt, 254);
      @(posedge clk);
      #1;
    end
    chk("sat timeouts", tmo, 0);
    chk("err saturated", err_cnt, 255);

    // Reset mid-shift with cnt=4.
    stuck = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'h5F;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst sr_we", sr_we, 0);
    chk("midrst sr_in", sr_in, 0);
    chk("midrst busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst req_ready", req_ready, 1);
    chk("midrst busy after", busy, 0);
    chk("midrst err_cnt", err_cnt, 0);
    chk("midrst rsp_data", rsp_data, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midrst no rsp", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
